pacman_mover: RTL and testbench
===============================

// Module: pacman_mover
// PURPOSE
//  Grid-step movement controller for Pac-Man; direct consumer of map_lut (27x24 tile map, q=1 wall).
//  Holds the tile position, buffers player turn requests, queries map_lut once per neighbour check
//  and advances one tile per move_tick unless blocked. Feeds position/direction to the renderer.
// PARAMETERS
//  START_X    13  reset tile column (0..26)
//  START_Y    18  reset tile row (0..23)
//  START_DIR  3   reset direction; encoding 0=up(y-1) 1=right(x+1) 2=down(y+1) 3=left(x-1)
// PORTS
//  clk            in   1  system clock, all state on rising edge
//  resetn         in   1  asynchronous, active-low reset
//  move_tick      in   1  one-cycle step strobe
//  dir_req_valid  in   1  player direction request strobe
//  dir_req        in   2  requested direction (encoding above)
//  map_x          out  8  tile column address to map_lut
//  map_y          out  7  tile row address to map_lut
//  map_wall       in   1  map_lut q, combinational from map_x/map_y, sampled same cycle
//  pos_x          out  8  current tile column
//  pos_y          out  7  current tile row
//  dir_cur        out  2  current travel direction
//  moving         out  1  1 = last step advanced, 0 = last step blocked
//  step_done      out  1  one-cycle pulse when a step attempt completes
//  busy           out  1  1 while FSM not in IDLE
// BEHAVIOUR
//  Reset: pos=(START_X,START_Y), dir_cur=START_DIR, pend_valid=0, moving=0, step_done=0, busy=0, FSM=IDLE.
//  Request buffer: dir_req_valid latches dir_req into pend (latest wins, any state); pend_valid
//   cleared only when adopted; blocked request stays pending for later ticks.
//  FSM: IDLE -> on move_tick: CHK_REQ if pend_valid else CHK_CUR.
//   CHK_REQ: addr = neighbour(pos,pend); if in-range and !map_wall: dir_cur<=pend, pend_valid<=0, ->MOVE;
//    else ->CHK_CUR.
//   CHK_CUR: addr = neighbour(pos,dir_cur); free -> MOVE; blocked -> moving<=0, step_done<=1, ->IDLE.
//   MOVE: pos<=neighbour, moving<=1, step_done<=1, ->IDLE.
//  Latency: new pos and step_done visible 2 clocks after tick (no pending / pending adopted), 3 when
//   pending request falls back to dir_cur. busy=1 for those cycles.
//  move_tick while busy: ignored (no queuing). dir_req_valid coincident with move_tick in IDLE:
//   new request is used for that step.
//  Range: neighbour with x>26, y>23 or underflow is a wall regardless of map_wall (map_lut returns
//   0 out of range). map_x/map_y in IDLE drive current pos.
//  Reset mid-operation: returns to reset values immediately; no step_done emitted.
// CONFIGURATION
//  TUNNEL_WRAP_EN defined: left from x=0 targets x=26, right from x=26 targets x=0 (same row); map
//   checked at wrapped tile; pos wraps. Not defined: those neighbours are out of range = wall.
// TESTING
//  1 reset, defaults -> pos=(13,18), dir_cur=3, moving=0, busy=0, step_done=0.
//  2 defaults, tick, no request -> 2 clk later pos=(12,18), moving=1, step_done one pulse.
//  3 defaults, req up then tick -> (13,17) wall, falls back: pos=(12,18), dir_cur=3, pend kept;
//    next tick -> pos=(12,17), dir_cur=0, pend_valid=0.
//  4 START=(0,10) dir 3, tick -> with TUNNEL_WRAP_EN pos=(26,10); without pos=(0,10), moving=0.
//  5 START=(1,10) dir 0, tick -> (1,9) wall: pos unchanged, moving=0, step_done pulse after 1 clk.
//  6 tick then resetn low during CHK_* -> outputs at reset values at once, no step_done; tick while
//    busy -> exactly one step taken.

Source files
------------

// File: rtl/pacman_mover.sv
// Grid-step Pac-Man movement controller: buffers turn requests, probes map_lut per neighbour, steps one tile per move_tick.
// Optional TUNNEL_WRAP_EN: horizontal tunnel wrap between x=0 and x=26 on the same row.
module pacman_mover #(
    parameter logic [7:0] START_X   = 8'd13,
    parameter logic [6:0] START_Y   = 7'd18,
    parameter logic [1:0] START_DIR = 2'd3
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       move_tick,
    input  logic       dir_req_valid,
    input  logic [1:0] dir_req,
    output logic [7:0] map_x,
    output logic [6:0] map_y,
    input  logic       map_wall,
    output logic [7:0] pos_x,
    output logic [6:0] pos_y,
    output logic [1:0] dir_cur,
    output logic       moving,
    output logic       step_done,
    output logic       busy
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CHK_REQ = 2'd1;
    localparam logic [1:0] S_CHK_CUR = 2'd2;
    localparam logic [1:0] S_MOVE    = 2'd3;

    logic [1:0] state;
    logic [1:0] pend;
    logic       pend_valid;
    logic [1:0] look_dir;
    logic [7:0] nx;
    logic [6:0] ny;
    logic       out_range;
    logic       free;

    // Underflow wraps to 255 / 127, so the range check below also catches it.
    always_comb begin
        look_dir  = (state == S_CHK_REQ) ? pend : dir_cur;
        nx        = pos_x;
        ny        = pos_y;
        case (look_dir)
            2'd0:    ny = pos_y - 7'd1;
            2'd1:    nx = pos_x + 8'd1;
            2'd2:    ny = pos_y + 7'd1;
            default: nx = pos_x - 8'd1;
        endcase
`ifdef TUNNEL_WRAP_EN
        if (look_dir == 2'd3 && pos_x == 8'd0)  nx = 8'd26;
        if (look_dir == 2'd1 && pos_x == 8'd26) nx = 8'd0;
`endif
        out_range = (nx > 8'd26) || (ny > 7'd23);
    end

    assign free  = !out_range && !map_wall;
    assign map_x = (state == S_IDLE) ? pos_x : nx;
    assign map_y = (state == S_IDLE) ? pos_y : ny;
    assign busy  = (state != S_IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            pos_x      <= START_X;
            pos_y      <= START_Y;
            dir_cur    <= START_DIR;
            pend       <= 2'd0;
            pend_valid <= 1'b0;
            moving     <= 1'b0;
            step_done  <= 1'b0;
        end else begin
            step_done <= 1'b0;
            if (dir_req_valid) begin
                pend       <= dir_req;
                pend_valid <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    // A request arriving with the tick is latched this edge and used for this step.
                    if (move_tick)
                        state <= (pend_valid || dir_req_valid) ? S_CHK_REQ : S_CHK_CUR;
                end
                S_CHK_REQ: begin
                    if (free) begin
                        dir_cur <= pend;
                        if (!dir_req_valid)
                            pend_valid <= 1'b0;
                        state <= S_MOVE;
                    end else begin
                        state <= S_CHK_CUR;
                    end
                end
                S_CHK_CUR: begin
                    if (free) begin
                        state <= S_MOVE;
                    end else begin
                        moving    <= 1'b0;
                        step_done <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    pos_x     <= nx;
                    pos_y     <= ny;
                    moving    <= 1'b1;
                    step_done <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pacman_mover.sv
// Directed bench for pacman_mover: three instances (default start, left edge, below a wall) share stimulus.
module tb_pacman_mover;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       move_tick = 1'b0;
    logic       dir_req_valid = 1'b0;
    logic [1:0] dir_req = 2'd0;

    logic [7:0] a_mx, b_mx, c_mx, a_px, b_px, c_px;
    logic [6:0] a_my, b_my, c_my, a_py, b_py, c_py;
    logic       a_mw, b_mw, c_mw;
    logic [1:0] a_dir, b_dir, c_dir;
    logic       a_mov, b_mov, c_mov, a_sd, b_sd, c_sd, a_busy, b_busy, c_busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic logic wall_at(input logic [7:0] x, input logic [6:0] y);
        return (x == 8'd13 && y == 7'd17) || (x == 8'd1 && y == 7'd9);
    endfunction

    assign a_mw = wall_at(a_mx, a_my);
    assign b_mw = wall_at(b_mx, b_my);
    assign c_mw = wall_at(c_mx, c_my);

    pacman_mover dut_a (
        .clk(clk), .resetn(resetn), .move_tick(move_tick), .dir_req_valid(dir_req_valid),
        .dir_req(dir_req), .map_x(a_mx), .map_y(a_my), .map_wall(a_mw), .pos_x(a_px),
        .pos_y(a_py), .dir_cur(a_dir), .moving(a_mov), .step_done(a_sd), .busy(a_busy)
    );

    pacman_mover #(.START_X(8'd0), .START_Y(7'd10), .START_DIR(2'd3)) dut_b (
        .clk(clk), .resetn(resetn), .move_tick(move_tick), .dir_req_valid(dir_req_valid),
        .dir_req(dir_req), .map_x(b_mx), .map_y(b_my), .map_wall(b_mw), .pos_x(b_px),
        .pos_y(b_py), .dir_cur(b_dir), .moving(b_mov), .step_done(b_sd), .busy(b_busy)
    );

    pacman_mover #(.START_X(8'd1), .START_Y(7'd10), .START_DIR(2'd0)) dut_c (
        .clk(clk), .resetn(resetn), .move_tick(move_tick), .dir_req_valid(dir_req_valid),
        .dir_req(dir_req), .map_x(c_mx), .map_y(c_my), .map_wall(c_mw), .pos_x(c_px),
        .pos_y(c_py), .dir_cur(c_dir), .moving(c_mov), .step_done(c_sd), .busy(c_busy)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        move_tick = 1'b0;
        dir_req_valid = 1'b0;
        dir_req = 2'd0;
        cyc();
        resetn = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({a_px, a_py} !== {8'd13, 7'd18}) begin errors++; $display("FAIL reset_pos got=(%0d,%0d) exp=(13,18)", a_px, a_py); end
        checks++; if (a_dir !== 2'd3) begin errors++; $display("FAIL reset_dir got=%0d exp=3", a_dir); end
        checks++; if ({a_mov, a_busy, a_sd} !== 3'b000) begin errors++; $display("FAIL reset_flags moving/busy/step_done got=%b exp=000", {a_mov, a_busy, a_sd}); end
        checks++; if ({a_mx, a_my} !== {8'd13, 7'd18}) begin errors++; $display("FAIL idle_map_addr got=(%0d,%0d) exp=(13,18)", a_mx, a_my); end
    endtask

    task automatic test_step();
        do_reset();
        move_tick = 1'b1;
        cyc();
        move_tick = 1'b0;
        checks++; if ({a_busy, a_sd} !== 2'b10) begin errors++; $display("FAIL step_busy1 busy/sd got=%b exp=10", {a_busy, a_sd}); end
        checks++; if ({a_mx, a_my} !== {8'd12, 7'd18}) begin errors++; $display("FAIL step_probe got=(%0d,%0d) exp=(12,18)", a_mx, a_my); end
        cyc();
        checks++; if ({a_px, a_sd, a_busy} !== {8'd13, 1'b0, 1'b1}) begin errors++; $display("FAIL step_early got px=%0d sd=%b busy=%b exp 13 0 1", a_px, a_sd, a_busy); end
        cyc();
        checks++; if ({a_px, a_py, a_mov, a_sd, a_busy} !== {8'd12, 7'd18, 1'b1, 1'b1, 1'b0}) begin
            errors++; $display("FAIL step_done got=(%0d,%0d) mov=%b sd=%b busy=%b exp (12,18) 1 1 0", a_px, a_py, a_mov, a_sd, a_busy); end
        cyc();
        checks++; if (a_sd !== 1'b0) begin errors++; $display("FAIL step_pulse got sd=%b exp 0", a_sd); end
    endtask

    task automatic test_pending_fallback();
        do_reset();
        dir_req_valid = 1'b1;
        dir_req = 2'd0;
        cyc();
        dir_req_valid = 1'b0;
        move_tick = 1'b1;
        cyc();
        move_tick = 1'b0;
        cyc();
        cyc();
        checks++; if ({a_sd, a_busy} !== 2'b01) begin errors++; $display("FAIL fallback_early sd/busy got=%b exp=01", {a_sd, a_busy}); end
        cyc();
        checks++; if ({a_px, a_py, a_dir, a_sd} !== {8'd12, 7'd18, 2'd3, 1'b1}) begin
            errors++; $display("FAIL fallback_step got=(%0d,%0d) dir=%0d sd=%b exp (12,18) 3 1", a_px, a_py, a_dir, a_sd); end
        checks++; if (dut_a.pend_valid !== 1'b1) begin errors++; $display("FAIL fallback_pend_kept got=%b exp=1", dut_a.pend_valid); end
        move_tick = 1'b1;
        cyc();
        move_tick = 1'b0;
        cyc();
        cyc();
        checks++; if ({a_px, a_py, a_dir, a_sd} !== {8'd12, 7'd17, 2'd0, 1'b1}) begin
            errors++; $display("FAIL adopt_step got=(%0d,%0d) dir=%0d sd=%b exp (12,17) 0 1", a_px, a_py, a_dir, a_sd); end
        checks++; if (dut_a.pend_valid !== 1'b0) begin errors++; $display("FAIL adopt_pend_clear got=%b exp=0", dut_a.pend_valid); end
    endtask

    task automatic test_tunnel();
        do_reset();
        move_tick = 1'b1;
        cyc();
        move_tick = 1'b0;
        cyc();
`ifdef TUNNEL_WRAP_EN
        checks++; if (b_sd !== 1'b0) begin errors++; $display("FAIL tunnel_early sd got=%b exp=0", b_sd); end
        cyc();
        checks++; if ({b_px, b_py, b_mov, b_sd} !== {8'd26, 7'd10, 1'b1, 1'b1}) begin
            errors++; $display("FAIL tunnel_wrap got=(%0d,%0d) mov=%b sd=%b exp (26,10) 1 1", b_px, b_py, b_mov, b_sd); end
`else
        checks++; if ({b_px, b_py, b_mov, b_sd, b_busy} !== {8'd0, 7'd10, 1'b0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL tunnel_block got=(%0d,%0d) mov=%b sd=%b busy=%b exp (0,10) 0 1 0", b_px, b_py, b_mov, b_sd, b_busy); end
`endif
    endtask

    task automatic test_blocked();
        do_reset();
        move_tick = 1'b1;
        cyc();
        move_tick = 1'b0;
        checks++; if ({c_sd, c_busy} !== 2'b01) begin errors++; $display("FAIL blocked_early sd/busy got=%b exp=01", {c_sd, c_busy}); end
        cyc();
        checks++; if ({c_px, c_py, c_mov, c_sd, c_busy} !== {8'd1, 7'd10, 1'b0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL blocked_step got=(%0d,%0d) mov=%b sd=%b busy=%b exp (1,10) 0 1 0", c_px, c_py, c_mov, c_sd, c_busy); end
    endtask

    task automatic test_coincident_req();
        do_reset();
        move_tick = 1'b1;
        dir_req_valid = 1'b1;
        dir_req = 2'd2;
        cyc();
        move_tick = 1'b0;
        dir_req_valid = 1'b0;
        cyc();
        cyc();
        checks++; if ({a_px, a_py, a_dir, a_sd} !== {8'd13, 7'd19, 2'd2, 1'b1}) begin
            errors++; $display("FAIL coincident_req got=(%0d,%0d) dir=%0d sd=%b exp (13,19) 2 1", a_px, a_py, a_dir, a_sd); end
    endtask

    task automatic test_back_to_back();
        logic saw_sd;
        do_reset();
        move_tick = 1'b1;
        cyc();
        move_tick = 1'b0;
        cyc();
        cyc();
        move_tick = 1'b1;
        cyc();
        move_tick = 1'b0;
        resetn = 1'b0;
        #1;
        checks++; if ({a_px, a_py, a_dir, a_mov, a_sd, a_busy} !== {8'd13, 7'd18, 2'd3, 1'b0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL mid_reset got=(%0d,%0d) dir=%0d mov=%b sd=%b busy=%b exp (13,18) 3 0 0 0", a_px, a_py, a_dir, a_mov, a_sd, a_busy); end
        resetn = 1'b1;
        saw_sd = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (a_sd) saw_sd = 1'b1;
        end
        checks++; if ({saw_sd, a_px} !== {1'b0, 8'd13}) begin errors++; $display("FAIL mid_reset_quiet got sd_seen=%b px=%0d exp 0 13", saw_sd, a_px); end
        move_tick = 1'b1;
        cyc();
        cyc();
        move_tick = 1'b0;
        cyc();
        checks++; if ({a_px, a_sd} !== {8'd12, 1'b1}) begin errors++; $display("FAIL b2b_first got px=%0d sd=%b exp 12 1", a_px, a_sd); end
        for (int i = 0; i < 4; i++) cyc();
        checks++; if ({a_px, a_busy} !== {8'd12, 1'b0}) begin errors++; $display("FAIL b2b_single got px=%0d busy=%b exp 12 0", a_px, a_busy); end
    endtask

    initial begin
        test_reset();
        test_step();
        test_pending_fallback();
        test_tunnel();
        test_blocked();
        test_coincident_req();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
